pipe_credit_ctrl: RTL and testbench

Flow controller for a fixed-latency, clock-enable-gated delay pipeline (`ft_delay`-style datapath of depth DEP). It turns the pipeline's free-running shift behaviour into a valid/ready stream. Results are captured in a credit-protected output FIFO, so downstream back-pressure never stalls or overflows the datapath. It sits between an upstream producer, the instanced delay pipeline, and a downstream consumer.

---
 rtl/pipe_ctrl_pkg.sv | 15 +
 rtl/pipe_credit_fifo.sv | 71 +++++++
 rtl/pipe_credit_ctrl.sv | 101 ++++++++++
 tb/tb_pipe_credit_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Sizing helpers shared by the pipeline credit controller and its output FIFO.
package pipe_ctrl_pkg;

    function automatic int cnt_w(int n);
        return $clog2(n + 1);
    endfunction

    function automatic int FDEP_MIN_FULLRATE(int dep);
        return dep + 2;
    endfunction

    localparam int DEP_DEFAULT  = 4;
    localparam int FDEP_DEFAULT = FDEP_MIN_FULLRATE(DEP_DEFAULT);

endpackage

// File: rtl/pipe_credit_fifo.sv
// Synchronous FIFO with registered pointers and a fall-through head; zero-cycle read of head.
// Caller guarantees no write when full (credit protected); reads when empty are ignored.
module pipe_credit_fifo
    import pipe_ctrl_pkg::*;
#(
    parameter int WID  = 32,
    parameter int FDEP = 6
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           wr,
    input  logic [WID-1:0] wdat,
    input  logic           rd,
    output logic [WID-1:0] rdat,
    output logic           empty,
    output logic           full
);
    localparam int PW = (FDEP > 1) ? $clog2(FDEP) : 1;
    localparam int CW = cnt_w(FDEP);

    logic [WID-1:0] mem_q [FDEP];
    logic [PW-1:0]  wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]  lvl_q, lvl_d;
    logic           do_rd;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FDEP - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_rd = rd & ~empty;
    assign empty = (lvl_q == '0);
    assign full  = (lvl_q == CW'(FDEP));
    assign rdat  = mem_q[rp_q];

    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        lvl_d = lvl_q;
        if (clr) begin
            wp_d  = '0;
            rp_d  = '0;
            lvl_d = '0;
        end else begin
            if (wr)    wp_d = ptr_inc(wp_q);
            if (do_rd) rp_d = ptr_inc(rp_q);
            case ({wr, do_rd})
                2'b10:   lvl_d = lvl_q + 1'b1;
                2'b01:   lvl_d = lvl_q - 1'b1;
                default: lvl_d = lvl_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            lvl_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            lvl_q <= lvl_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr && !clr) mem_q[wp_q] <= wdat;
    end

endmodule

// File: rtl/pipe_credit_ctrl.sv
// Valid/ready wrapper around a ce-gated fixed-latency pipeline; item appears on m_* DEP+1 ce-cycles after accept.
// Downstream stalls are absorbed by a credit-sized FIFO; s_ready drops only when all FDEP credits are used.
module pipe_credit_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int WID  = 32,
    parameter int DEP  = DEP_DEFAULT,
    parameter int FDEP = FDEP_MIN_FULLRATE(DEP)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ce,
    input  logic           flush,
    input  logic           s_valid,
    output logic           s_ready,
    input  logic [WID-1:0] s_data,
    output logic           dp_ce,
    output logic [WID-1:0] dp_i,
    input  logic [WID-1:0] dp_o,
    output logic           m_valid,
    input  logic           m_ready,
    output logic [WID-1:0] m_data,
    output logic           busy
);
    localparam int CW = cnt_w(FDEP);

    logic [DEP-1:0] vld_q, vld_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]  lvl_q, lvl_d;
    logic           acc, pop, fifo_wr, fifo_empty, fifo_full;

    assign dp_ce   = ce;
    assign dp_i    = s_data;
    assign s_ready = (cnt_q < CW'(FDEP));
    assign m_valid = ~fifo_empty;
    assign busy    = (cnt_q != '0);

    // flush blocks both handshakes even though ready/valid stay visible
    assign acc     = ce & s_valid & s_ready & ~flush;
    assign pop     = ce & m_valid & m_ready & ~flush;
    assign fifo_wr = ce & vld_q[DEP-1] & ~flush;

    always_comb begin
        vld_d = vld_q;
        cnt_d = cnt_q;
        lvl_d = lvl_q;
        if (flush) begin
            vld_d = '0;
            cnt_d = '0;
            lvl_d = '0;
        end else if (ce) begin
            vld_d    = vld_q << 1;
            vld_d[0] = acc;
            case ({acc, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
            case ({fifo_wr, pop})
                2'b10:   lvl_d = lvl_q + 1'b1;
                2'b01:   lvl_d = lvl_q - 1'b1;
                default: lvl_d = lvl_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            cnt_q <= '0;
            lvl_q <= '0;
        end else begin
            vld_q <= vld_d;
            cnt_q <= cnt_d;
            lvl_q <= lvl_d;
        end
    end

    pipe_credit_fifo #(
        .WID  (WID),
        .FDEP (FDEP)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .wr    (fifo_wr),
        .wdat  (dp_o),
        .rd    (pop),
        .rdat  (m_data),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // lvl_q mirrors FIFO occupancy so credits can be cross-checked against items held
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(fifo_wr && fifo_full));
    a_lvl_match:   assert property (@(posedge clk) disable iff (rst) ((lvl_q == '0) == fifo_empty));
    a_cnt_sum:     assert property (@(posedge clk) disable iff (rst)
                                    (int'(cnt_q) == $countones(vld_q) + int'(lvl_q)));
    a_cnt_max:     assert property (@(posedge clk) disable iff (rst) (int'(cnt_q) <= FDEP));

endmodule

// File: tb/tb_pipe_credit_ctrl.sv
// Directed bench: DUT A uses DEP=4/FDEP=6, DUT B uses DEP=4/FDEP=2; each drives a modelled ce-gated delay line.
`timescale 1ns/1ps
module tb_pipe_credit_ctrl;
    localparam int WID = 32;
    localparam int DEP = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic           ce_a, flush_a, s_valid_a, s_ready_a, dp_ce_a, m_valid_a, m_ready_a, busy_a;
    logic [WID-1:0] s_data_a, dp_i_a, dp_o_a, m_data_a;
    logic           ce_b, flush_b, s_valid_b, s_ready_b, dp_ce_b, m_valid_b, m_ready_b, busy_b;
    logic [WID-1:0] s_data_b, dp_i_b, dp_o_b, m_data_b;
    logic [WID-1:0] pipe_a [DEP];
    logic [WID-1:0] pipe_b [DEP];

    int n_chk  = 0;
    int n_pass = 0;

    pipe_credit_ctrl #(.WID(WID), .DEP(DEP), .FDEP(6)) u_dut_a (
        .clk(clk), .rst(rst), .ce(ce_a), .flush(flush_a),
        .s_valid(s_valid_a), .s_ready(s_ready_a), .s_data(s_data_a),
        .dp_ce(dp_ce_a), .dp_i(dp_i_a), .dp_o(dp_o_a),
        .m_valid(m_valid_a), .m_ready(m_ready_a), .m_data(m_data_a), .busy(busy_a)
    );

    pipe_credit_ctrl #(.WID(WID), .DEP(DEP), .FDEP(2)) u_dut_b (
        .clk(clk), .rst(rst), .ce(ce_b), .flush(flush_b),
        .s_valid(s_valid_b), .s_ready(s_ready_b), .s_data(s_data_b),
        .dp_ce(dp_ce_b), .dp_i(dp_i_b), .dp_o(dp_o_b),
        .m_valid(m_valid_b), .m_ready(m_ready_b), .m_data(m_data_b), .busy(busy_b)
    );

    // delay-line models standing in for the instanced datapath
    always @(posedge clk) begin
        if (dp_ce_a) begin
            pipe_a[0] <= dp_i_a;
            for (int k = 1; k < DEP; k++) pipe_a[k] <= pipe_a[k-1];
        end
        if (dp_ce_b) begin
            pipe_b[0] <= dp_i_b;
            for (int k = 1; k < DEP; k++) pipe_b[k] <= pipe_b[k-1];
        end
    end
    assign dp_o_a = pipe_a[DEP-1];
    assign dp_o_b = pipe_b[DEP-1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ce_a = 1'b1; flush_a = 1'b0; s_valid_a = 1'b0; m_ready_a = 1'b0; s_data_a = 32'h1234_5678;
        ce_b = 1'b1; flush_b = 1'b0; s_valid_b = 1'b0; m_ready_b = 1'b0; s_data_b = '0;
        tick();
        tick();
        n_chk++; if (s_ready_a !== 1'b1) $display("FAIL reset_s_ready: got %b exp 1", s_ready_a); else n_pass++;
        n_chk++; if (m_valid_a !== 1'b0) $display("FAIL reset_m_valid: got %b exp 0", m_valid_a); else n_pass++;
        n_chk++; if (busy_a !== 1'b0) $display("FAIL reset_busy: got %b exp 0", busy_a); else n_pass++;
        n_chk++; if (dp_ce_a !== 1'b1) $display("FAIL reset_dp_ce_hi: got %b exp 1", dp_ce_a); else n_pass++;
        n_chk++; if (dp_i_a !== 32'h1234_5678) $display("FAIL reset_dp_i: got %h exp 12345678", dp_i_a); else n_pass++;
        ce_a = 1'b0;
        #1;
        n_chk++; if (dp_ce_a !== 1'b0) $display("FAIL reset_dp_ce_lo: got %b exp 0", dp_ce_a); else n_pass++;
        ce_a = 1'b1;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [WID-1:0] got[$];
        int sent = 0, drops = 0, first_acc = -1, first_mv = -1;
        m_ready_a = 1'b1;
        for (int i = 0; i < 60; i++) begin
            s_valid_a = (sent < 20);
            s_data_a  = 32'(sent);
            #1;
            if (sent < 20 && !s_ready_a) drops++;
            if (m_valid_a && first_mv < 0) first_mv = i;
            if (m_valid_a && m_ready_a) got.push_back(m_data_a);
            if (s_valid_a && s_ready_a) begin
                if (first_acc < 0) first_acc = i;
                sent++;
            end
            tick();
        end
        s_valid_a = 1'b0;
        n_chk++; if (first_mv - first_acc !== 5) $display("FAIL b2b_latency: got %0d exp 5", first_mv - first_acc); else n_pass++;
        n_chk++; if (drops !== 0) $display("FAIL b2b_ready_drops: got %0d exp 0", drops); else n_pass++;
        n_chk++; if (got.size() !== 20) $display("FAIL b2b_count: got %0d exp 20", got.size()); else n_pass++;
        for (int k = 0; k < got.size(); k++) begin
            n_chk++; if (got[k] !== 32'(k)) $display("FAIL b2b_data[%0d]: got %0h exp %0h", k, got[k], k); else n_pass++;
        end
        n_chk++; if (busy_a !== 1'b0) $display("FAIL b2b_idle: got %b exp 0", busy_a); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [WID-1:0] got[$];
        int sent = 0, first_pop = -1, resume = -1;
        m_ready_a = 1'b0;
        for (int i = 0; i < 15; i++) begin
            s_valid_a = 1'b1;
            s_data_a  = 32'(100 + sent);
            #1;
            if (s_ready_a) sent++;
            tick();
        end
        n_chk++; if (sent !== 6) $display("FAIL bp_accepted: got %0d exp 6", sent); else n_pass++;
        n_chk++; if (s_ready_a !== 1'b0) $display("FAIL bp_s_ready: got %b exp 0", s_ready_a); else n_pass++;
        n_chk++; if (m_valid_a !== 1'b1) $display("FAIL bp_m_valid: got %b exp 1", m_valid_a); else n_pass++;
        m_ready_a = 1'b1;
        for (int i = 0; i < 60 && got.size() < 10; i++) begin
            s_valid_a = (sent < 10);
            s_data_a  = 32'(100 + sent);
            #1;
            if (m_valid_a) begin
                if (first_pop < 0) first_pop = i;
                got.push_back(m_data_a);
            end
            if (s_valid_a && s_ready_a) begin
                if (resume < 0) resume = i;
                sent++;
            end
            tick();
        end
        s_valid_a = 1'b0;
        n_chk++; if (resume - first_pop !== 1) $display("FAIL bp_resume: got %0d exp 1", resume - first_pop); else n_pass++;
        n_chk++; if (got.size() !== 10) $display("FAIL bp_count: got %0d exp 10", got.size()); else n_pass++;
        for (int k = 0; k < got.size(); k++) begin
            n_chk++; if (got[k] !== 32'(100 + k)) $display("FAIL bp_data[%0d]: got %0h exp %0h", k, got[k], 100 + k); else n_pass++;
        end
        n_chk++; if (busy_a !== 1'b0) $display("FAIL bp_idle: got %b exp 0", busy_a); else n_pass++;
    endtask

    task automatic test_ce_gating();
        logic [WID-1:0] got[$];
        int highs = 0, highs_before = -1, first_mv = -1, pop_idx = -1;
        m_ready_a = 1'b1;
        s_data_a  = 32'h55;
        for (int i = 0; i < 14; i++) begin
            ce_a      = (i % 2 == 0);
            s_valid_a = (i == 0);
            #1;
            if (m_valid_a && first_mv < 0) begin
                first_mv     = i;
                highs_before = highs;
            end
            if (ce_a && m_valid_a) begin
                pop_idx = i;
                got.push_back(m_data_a);
            end
            if (ce_a) highs++;
            tick();
        end
        ce_a = 1'b1;
        s_valid_a = 1'b0;
        n_chk++; if (highs_before !== 5) $display("FAIL ce_high_cycles: got %0d exp 5", highs_before); else n_pass++;
        n_chk++; if (first_mv !== 9) $display("FAIL ce_first_mv: got %0d exp 9", first_mv); else n_pass++;
        n_chk++; if (pop_idx !== 10) $display("FAIL ce_pop_cycle: got %0d exp 10", pop_idx); else n_pass++;
        n_chk++; if (got.size() !== 1) $display("FAIL ce_count: got %0d exp 1", got.size()); else n_pass++;
        if (got.size() > 0) begin
            n_chk++; if (got[0] !== 32'h55) $display("FAIL ce_data: got %0h exp 55", got[0]); else n_pass++;
        end
        n_chk++; if (busy_a !== 1'b0) $display("FAIL ce_idle: got %b exp 0", busy_a); else n_pass++;
    endtask

    task automatic test_flush();
        int sent = 0, mv_seen = 0;
        m_ready_a = 1'b0;
        for (int i = 0; i < 6; i++) begin
            s_valid_a = (i < 5);
            s_data_a  = 32'(200 + i);
            #1;
            if (s_valid_a && s_ready_a) sent++;
            tick();
        end
        n_chk++; if (sent !== 5) $display("FAIL fl_accepted: got %0d exp 5", sent); else n_pass++;
        flush_a = 1'b1; s_valid_a = 1'b1; s_data_a = 32'hDEAD; m_ready_a = 1'b1;
        #1;
        n_chk++; if (s_ready_a !== 1'b1) $display("FAIL fl_s_ready_shown: got %b exp 1", s_ready_a); else n_pass++;
        n_chk++; if (m_valid_a !== 1'b1) $display("FAIL fl_m_valid_shown: got %b exp 1", m_valid_a); else n_pass++;
        n_chk++; if (m_data_a !== 32'd200) $display("FAIL fl_head: got %0h exp c8", m_data_a); else n_pass++;
        tick();
        flush_a = 1'b0; s_valid_a = 1'b0;
        #1;
        n_chk++; if (busy_a !== 1'b0) $display("FAIL fl_busy: got %b exp 0", busy_a); else n_pass++;
        n_chk++; if (m_valid_a !== 1'b0) $display("FAIL fl_m_valid: got %b exp 0", m_valid_a); else n_pass++;
        n_chk++; if (s_ready_a !== 1'b1) $display("FAIL fl_s_ready: got %b exp 1", s_ready_a); else n_pass++;
        for (int i = 0; i < 12; i++) begin
            if (m_valid_a) mv_seen++;
            tick();
        end
        n_chk++; if (mv_seen !== 0) $display("FAIL fl_leak: got %0d exp 0", mv_seen); else n_pass++;
    endtask

    task automatic test_reset_midstream();
        logic [WID-1:0] got[$];
        int sent = 0, first_mv = -1;
        m_ready_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_valid_a = 1'b1;
            s_data_a  = 32'(300 + i);
            #1;
            if (s_ready_a) sent++;
            tick();
        end
        n_chk++; if (sent !== 4) $display("FAIL rm_accepted: got %0d exp 4", sent); else n_pass++;
        s_valid_a = 1'b0; ce_a = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0; ce_a = 1'b1;
        #1;
        n_chk++; if (s_ready_a !== 1'b1) $display("FAIL rm_s_ready: got %b exp 1", s_ready_a); else n_pass++;
        n_chk++; if (m_valid_a !== 1'b0) $display("FAIL rm_m_valid: got %b exp 0", m_valid_a); else n_pass++;
        n_chk++; if (busy_a !== 1'b0) $display("FAIL rm_busy: got %b exp 0", busy_a); else n_pass++;
        for (int i = 0; i < 12; i++) begin
            s_valid_a = (i == 0);
            s_data_a  = 32'hA5;
            #1;
            if (m_valid_a) begin
                if (first_mv < 0) first_mv = i;
                got.push_back(m_data_a);
            end
            tick();
        end
        s_valid_a = 1'b0;
        n_chk++; if (first_mv !== 5) $display("FAIL rm_latency: got %0d exp 5", first_mv); else n_pass++;
        n_chk++; if (got.size() !== 1) $display("FAIL rm_count: got %0d exp 1", got.size()); else n_pass++;
        if (got.size() > 0) begin
            n_chk++; if (got[0] !== 32'hA5) $display("FAIL rm_data: got %0h exp a5", got[0]); else n_pass++;
        end
    endtask

    task automatic test_low_credit();
        logic [WID-1:0] got[$];
        int sent = 0, viol = 0;
        m_ready_b = 1'b1;
        for (int i = 0; i < 36; i++) begin
            s_valid_b = 1'b1;
            s_data_b  = 32'(sent);
            #1;
            if (m_valid_b) got.push_back(m_data_b);
            if (s_ready_b) begin
                if (i % 6 >= 2) viol++;
                sent++;
            end
            tick();
        end
        s_valid_b = 1'b0;
        n_chk++; if (sent !== 12) $display("FAIL lc_accepted: got %0d exp 12", sent); else n_pass++;
        n_chk++; if (got.size() !== 11) $display("FAIL lc_popped: got %0d exp 11", got.size()); else n_pass++;
        n_chk++; if (viol !== 0) $display("FAIL lc_pattern: got %0d exp 0", viol); else n_pass++;
        for (int k = 0; k < got.size(); k++) begin
            n_chk++; if (got[k] !== 32'(k)) $display("FAIL lc_data[%0d]: got %0h exp %0h", k, got[k], k); else n_pass++;
        end
        for (int i = 0; i < 8; i++) tick();
        n_chk++; if (busy_b !== 1'b0) $display("FAIL lc_idle: got %b exp 0", busy_b); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        #1;
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_ce_gating();
        test_flush();
        test_reset_midstream();
        test_low_credit();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
